// File: rtl/register_bank.sv
// register_bank: 32 x 32-bit register file, two combinational read ports,
// one write port, and a 16-bit committed-write counter.
// Register 0 reads as zero. Writes to index 0 are dropped and not counted.
// Optional build macro: REGBANK_BYPASS_EN. When it is defined, a pending
// write is forwarded to any read port that addresses the same register in
// the same cycle.
module register_bank (
  input  logic        clk,
  input  logic        rst,
  input  logic        RegWrite,
  input  logic [4:0]  wrAddr,
  input  logic [31:0] wrData,
  input  logic [4:0]  rsAddr,
  input  logic [4:0]  rtAddr,
  output logic [31:0] rsData,
  output logic [31:0] rtData,
  output logic [15:0] wrCount
);

  localparam int NUM_REGS = 32;
  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 5;
  localparam int NUM_RD   = 2;

  logic [NUM_REGS-1:0][DATA_W-1:0] regs_q, regs_d;
  logic [15:0]                     cnt_q, cnt_d;
  logic                            wr_en;

  logic [NUM_RD-1:0][ADDR_W-1:0]   rd_addr;
  logic [NUM_RD-1:0][DATA_W-1:0]   rd_data;

  // Index 0 is hard-wired to zero, so a write aimed at it never commits.
  assign wr_en = RegWrite && (wrAddr != '0);

  // Next state for the storage and the write counter.
  always_comb begin
    regs_d = regs_q;
    cnt_d  = cnt_q;
    if (wr_en) begin
      regs_d[wrAddr] = wrData;
      cnt_d          = cnt_q + 16'd1;   // wraps 0xFFFF -> 0x0000
    end
  end

  // State registers. Reset clears the bank immediately and wins over any
  // write presented on the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      regs_q <= '0;
      cnt_q  <= '0;
    end else begin
      regs_q <= regs_d;
      cnt_q  <= cnt_d;
    end
  end

  assign rd_addr[0] = rsAddr;
  assign rd_addr[1] = rtAddr;

  // The read ports are identical, so they are built from a single loop.
  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    logic [DATA_W-1:0] data;

    // Combinational read. The result is forced to zero for index 0 and
    // while rst is high, so forwarding can never leak through in those cases.
    always_comb begin
      data = regs_q[rd_addr[p]];
`ifdef REGBANK_BYPASS_EN
      if (wr_en && (rd_addr[p] == wrAddr)) data = wrData;
`endif
      if (rst || (rd_addr[p] == '0)) data = '0;
    end

    assign rd_data[p] = data;
  end

  assign rsData  = rd_data[0];
  assign rtData  = rd_data[1];
  assign wrCount = cnt_q;

endmodule

// File: tb/tb_register_bank.sv
// Directed testbench for register_bank. Every expected value below is
// written by hand.
module tb_register_bank;

  logic        clk = 1'b0;
  logic        rst;
  logic        RegWrite;
  logic [4:0]  wrAddr;
  logic [31:0] wrData;
  logic [4:0]  rsAddr;
  logic [4:0]  rtAddr;
  logic [31:0] rsData;
  logic [31:0] rtData;
  logic [15:0] wrCount;

  int checks   = 0;
  int failures = 0;

  register_bank dut (
    .clk      (clk),
    .rst      (rst),
    .RegWrite (RegWrite),
    .wrAddr   (wrAddr),
    .wrData   (wrData),
    .rsAddr   (rsAddr),
    .rtAddr   (rtAddr),
    .rsData   (rsData),
    .rtData   (rtData),
    .wrCount  (wrCount)
  );

  always #5 clk = ~clk;

  // Inputs change, and outputs are sampled, 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [4:0] a, input logic [31:0] d);
    RegWrite = 1'b1;
    wrAddr   = a;
    wrData   = d;
    step();
    RegWrite = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; RegWrite = 1'b1; wrAddr = 5'd3; wrData = 32'h0000000A;
    rsAddr = 5'd3; rtAddr = 5'd3;
    step();
    step();
    checks++;
    if (rsData !== 32'h0) begin
      failures++; $display("FAIL reset_rs_in_reset got=%h exp=%h", rsData, 32'h0);
    end
    checks++;
    if (wrCount !== 16'h0) begin
      failures++; $display("FAIL reset_cnt_in_reset got=%h exp=%h", wrCount, 16'h0);
    end
    // Drop rst and RegWrite between edges; the write attempted during reset is lost.
    RegWrite = 1'b0;
    rst = 1'b0;
    step();
    checks++;
    if (rsData !== 32'h0) begin
      failures++; $display("FAIL reset_rs_after got=%h exp=%h", rsData, 32'h0);
    end
    checks++;
    if (wrCount !== 16'h0) begin
      failures++; $display("FAIL reset_cnt_after got=%h exp=%h", wrCount, 16'h0);
    end
  endtask

  task automatic test_write_read();
    do_write(5'd3, 32'h0000000A);
    do_write(5'd31, 32'h0000000B);
    rsAddr = 5'd3; rtAddr = 5'd31;
    #1;
    checks++;
    if (rsData !== 32'hA) begin
      failures++; $display("FAIL wr_rs3 got=%h exp=%h", rsData, 32'hA);
    end
    checks++;
    if (rtData !== 32'hB) begin
      failures++; $display("FAIL wr_rt31 got=%h exp=%h", rtData, 32'hB);
    end
    checks++;
    if (wrCount !== 16'd2) begin
      failures++; $display("FAIL wr_cnt got=%h exp=%h", wrCount, 16'd2);
    end
  endtask

  task automatic test_zero_reg();
    rsAddr = 5'd0; rtAddr = 5'd0;
    RegWrite = 1'b1; wrAddr = 5'd0; wrData = 32'hFFFFFFFF;
    #1;
    checks++;
    if (rsData !== 32'h0) begin
      failures++; $display("FAIL zero_no_fwd got=%h exp=%h", rsData, 32'h0);
    end
    step();
    RegWrite = 1'b0;
    checks++;
    if (rtData !== 32'h0) begin
      failures++; $display("FAIL zero_read got=%h exp=%h", rtData, 32'h0);
    end
    checks++;
    if (wrCount !== 16'd2) begin
      failures++; $display("FAIL zero_cnt got=%h exp=%h", wrCount, 16'd2);
    end
  endtask

  task automatic test_bypass();
    logic [31:0] exp_pre;
`ifdef REGBANK_BYPASS_EN
    exp_pre = 32'hC;
`else
    exp_pre = 32'h1;
`endif
    do_write(5'd5, 32'h1);
    rsAddr = 5'd5; rtAddr = 5'd5;
    RegWrite = 1'b1; wrAddr = 5'd5; wrData = 32'hC;
    #1;
    checks++;
    if (rsData !== exp_pre) begin
      failures++; $display("FAIL bypass_pre got=%h exp=%h", rsData, exp_pre);
    end
    checks++;
    if (rtData !== exp_pre) begin
      failures++; $display("FAIL bypass_pre_rt got=%h exp=%h", rtData, exp_pre);
    end
    step();
    RegWrite = 1'b0;
    checks++;
    if (rsData !== 32'hC) begin
      failures++; $display("FAIL bypass_post got=%h exp=%h", rsData, 32'hC);
    end
    checks++;
    if (wrCount !== 16'd4) begin
      failures++; $display("FAIL bypass_cnt got=%h exp=%h", wrCount, 16'd4);
    end
  endtask

  task automatic test_regwrite_low();
    RegWrite = 1'b0; wrAddr = 5'd7; wrData = 32'h12;
    rsAddr = 5'd7; rtAddr = 5'd3;
    for (int i = 0; i < 3; i++) step();
    checks++;
    if (rsData !== 32'h0) begin
      failures++; $display("FAIL rwlow_r7 got=%h exp=%h", rsData, 32'h0);
    end
    checks++;
    if (rtData !== 32'hA) begin
      failures++; $display("FAIL rwlow_r3 got=%h exp=%h", rtData, 32'hA);
    end
    checks++;
    if (wrCount !== 16'd4) begin
      failures++; $display("FAIL rwlow_cnt got=%h exp=%h", wrCount, 16'd4);
    end
  endtask

  task automatic test_back_to_back();
    RegWrite = 1'b1; wrAddr = 5'd9; wrData = 32'h11111111;
    step();
    wrData = 32'h22222222;
    step();
    RegWrite = 1'b0;
    rsAddr = 5'd9;
    #1;
    checks++;
    if (rsData !== 32'h22222222) begin
      failures++; $display("FAIL b2b_val got=%h exp=%h", rsData, 32'h22222222);
    end
    checks++;
    if (wrCount !== 16'd6) begin
      failures++; $display("FAIL b2b_cnt got=%h exp=%h", wrCount, 16'd6);
    end
  endtask

  task automatic test_wrap_and_reset();
    // Asynchronous reset between edges restarts the count from zero.
    rst = 1'b1;
    #1;
    rst = 1'b0;
    do_write(5'd4, 32'h44);
    checks++;
    if (wrCount !== 16'd1) begin
      failures++; $display("FAIL first_write_cnt got=%h exp=%h", wrCount, 16'd1);
    end
    // Another 65534 writes bring the count to 0xFFFF; address cycles 1..31.
    RegWrite = 1'b1;
    for (int i = 0; i < 65534; i++) begin
      wrAddr = 5'((i % 31) + 1);
      wrData = i;
      step();
    end
    RegWrite = 1'b0;
    checks++;
    if (wrCount !== 16'hFFFF) begin
      failures++; $display("FAIL preload_cnt got=%h exp=%h", wrCount, 16'hFFFF);
    end
    do_write(5'd31, 32'hDEADBEEF);
    checks++;
    if (wrCount !== 16'h0000) begin
      failures++; $display("FAIL wrap_cnt got=%h exp=%h", wrCount, 16'h0);
    end
    rsAddr = 5'd31; rtAddr = 5'd2;
    #1;
    checks++;
    if (rsData !== 32'hDEADBEEF) begin
      failures++; $display("FAIL link_r31 got=%h exp=%h", rsData, 32'hDEADBEEF);
    end
    // Register 2 was last written in iteration i=65504, since 65504 % 31 == 1.
    checks++;
    if (rtData !== 32'd65504) begin
      failures++; $display("FAIL r2_before_rst got=%h exp=%h", rtData, 32'd65504);
    end
    // Assert reset between edges with a write pending: outputs must clear at once.
    RegWrite = 1'b1; wrAddr = 5'd31; wrData = 32'h5;
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (rsData !== 32'h0) begin
      failures++; $display("FAIL midrst_rs got=%h exp=%h", rsData, 32'h0);
    end
    checks++;
    if (rtData !== 32'h0) begin
      failures++; $display("FAIL midrst_rt got=%h exp=%h", rtData, 32'h0);
    end
    checks++;
    if (wrCount !== 16'h0) begin
      failures++; $display("FAIL midrst_cnt got=%h exp=%h", wrCount, 16'h0);
    end
    step();
    RegWrite = 1'b0;
    rst = 1'b0;
    #1;
    checks++;
    if (rsData !== 32'h0) begin
      failures++; $display("FAIL rst_override_r31 got=%h exp=%h", rsData, 32'h0);
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_zero_reg();
    test_bypass();
    test_regwrite_low();
    test_back_to_back();
    test_wrap_and_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
